// File: rtl/alu_branch_unit.sv
// Execution and program-flow unit: 8-bit ALU with zero flag, PC incrementer,
// branch/jump target adder, flow select and the 32-bit program counter.
module alu_branch_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  DATA1,
    input  logic [7:0]  DATA2,
    input  logic [2:0]  ALUOP,
    input  logic        JUMP,
    input  logic        BRANCH,
    input  logic [7:0]  OFFSET,
    output logic [7:0]  RESULT,
    output logic        ZERO,
    output logic [31:0] PC,
    output logic [31:0] NEXT_PC
);

    logic [7:0]  alu_res;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] offset_ext;
    logic        take;

    // Reserved opcodes (3'b1xx) yield zero so ZERO reads high for them.
    always_comb begin
        alu_res = 8'h00;
        case (ALUOP)
            3'b000:  alu_res = DATA2;
            3'b001:  alu_res = DATA1 + DATA2;
            3'b010:  alu_res = DATA1 & DATA2;
            3'b011:  alu_res = DATA1 | DATA2;
            default: alu_res = 8'h00;
        endcase
    end

    assign RESULT = alu_res;
    assign ZERO   = ~|alu_res;

    // Offset is in words: sign-extend, then scale by 4.
    assign offset_ext = {{22{OFFSET[7]}}, OFFSET, 2'b00};
    assign pc_plus4   = pc_q + 32'd4;
    assign target     = pc_plus4 + offset_ext;
    assign take       = JUMP | (BRANCH & ZERO);
    assign pc_d       = take ? target : pc_plus4;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q <= 32'h0000_0000;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC      = pc_q;
    assign NEXT_PC = pc_d;

endmodule

// File: tb/tb_alu_branch_unit.sv
// Bench for alu_branch_unit: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_alu_branch_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [7:0]  DATA1 = 8'h00;
    logic [7:0]  DATA2 = 8'h00;
    logic [2:0]  ALUOP = 3'b000;
    logic        JUMP = 1'b0;
    logic        BRANCH = 1'b0;
    logic [7:0]  OFFSET = 8'h00;
    logic [7:0]  RESULT;
    logic        ZERO;
    logic [31:0] PC;
    logic [31:0] NEXT_PC;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc = 32'h0;
    bit          run = 1'b0;

    alu_branch_unit dut (
        .CLK(CLK), .RESET(RESET), .DATA1(DATA1), .DATA2(DATA2), .ALUOP(ALUOP),
        .JUMP(JUMP), .BRANCH(BRANCH), .OFFSET(OFFSET),
        .RESULT(RESULT), .ZERO(ZERO), .PC(PC), .NEXT_PC(NEXT_PC)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] m_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int s;
        if (op >= 3'd4) return 8'h00;
        if (op == 3'd0) return b;
        if (op == 3'd1) begin
            s = int'(a) + int'(b);
            return 8'(s % 256);
        end
        if (op == 3'd2) return a & b;
        return a | b;
    endfunction

    function automatic logic [31:0] m_next();
        bit          take;
        int          off;
        logic [31:0] base;
        take = JUMP || (BRANCH && (m_alu(ALUOP, DATA1, DATA2) == 8'h00));
        base = model_pc + 32'd4;
        if (!take) return base;
        off = int'($signed(OFFSET));
        return base + 32'(off * 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic tick();
        logic [31:0] nxt;
        nxt = m_next();
        @(posedge CLK);
        if (!RESET) model_pc = nxt;
        #1;
    endtask

    task automatic set_in(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic j, input logic br, input logic [7:0] off);
        ALUOP = op; DATA1 = a; DATA2 = b; JUMP = j; BRANCH = br; OFFSET = off;
    endtask

    initial begin
        fork
            forever begin
                @(negedge CLK);
                if (run) begin
                    chk("model_result", {24'h0, RESULT}, {24'h0, m_alu(ALUOP, DATA1, DATA2)});
                    chk("model_zero", {31'h0, ZERO}, {31'h0, m_alu(ALUOP, DATA1, DATA2) == 8'h00});
                    chk("model_pc", PC, model_pc);
                    chk("model_next_pc", NEXT_PC, m_next());
                end
            end
        join_none

        // Asynchronous reset between edges
        #2;
        RESET = 1'b1;
        model_pc = 32'h0;
        #1;
        run = 1'b1;
        chk("reset_pc", PC, 32'h0);
        chk("reset_next_pc", NEXT_PC, 32'd4);
        settle();
        RESET = 1'b0;
        tick(); chk("seq_pc_4", PC, 32'd4);
        tick(); chk("seq_pc_8", PC, 32'd8);
        tick(); chk("seq_pc_12", PC, 32'd12);

        // ALU operations, sequential flow (PC 12 -> 36)
        set_in(3'b000, 8'h11, 8'h5A, 1'b0, 1'b0, 8'h00); settle();
        chk("fwd", {24'h0, RESULT}, 32'h5A); tick();
        set_in(3'b001, 8'hC8, 8'h64, 1'b0, 1'b0, 8'h00); settle();
        chk("add_wrap", {24'h0, RESULT}, 32'h2C); chk("add_wrap_zero", {31'h0, ZERO}, 32'd0); tick();
        set_in(3'b001, 8'h05, 8'hFB, 1'b0, 1'b0, 8'h00); settle();
        chk("add_zero", {24'h0, RESULT}, 32'h00); chk("add_zero_flag", {31'h0, ZERO}, 32'd1); tick();
        set_in(3'b010, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h00); settle();
        chk("and", {24'h0, RESULT}, 32'h30); tick();
        set_in(3'b011, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'h00); settle();
        chk("or", {24'h0, RESULT}, 32'hFF); tick();
        set_in(3'b110, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'h00); settle();
        chk("reserved", {24'h0, RESULT}, 32'h00); chk("reserved_zero", {31'h0, ZERO}, 32'd1); tick();
        chk("seq_pc_36", PC, 32'd36);
        tick();
        chk("seq_pc_40", PC, 32'd40);

        // Reset mid-run from PC = 40
        RESET = 1'b1;
        model_pc = 32'h0;
        #1;
        chk("midrun_reset_pc", PC, 32'h0);
        settle();
        RESET = 1'b0;
        tick(); chk("after_reset_pc_4", PC, 32'd4);
        tick(); chk("after_reset_pc_8", PC, 32'd8);

        // Jumps
        set_in(3'b001, 8'h01, 8'h01, 1'b1, 1'b0, 8'h02); settle();
        chk("jump_fwd_next", NEXT_PC, 32'd20); tick();
        chk("jump_fwd_pc", PC, 32'd20);
        set_in(3'b001, 8'h01, 8'h01, 1'b1, 1'b0, 8'hFE); settle();
        chk("jump_back_next", NEXT_PC, 32'd16); tick();
        chk("jump_back_pc", PC, 32'd16);
        settle(); tick();
        chk("jump_back2_pc", PC, 32'd12);

        // Branch taken / not taken at PC = 12
        set_in(3'b001, 8'h07, 8'hF9, 1'b0, 1'b1, 8'h01);
        #2;
        chk("branch_taken_zero", {31'h0, ZERO}, 32'd1);
        chk("branch_taken_next", NEXT_PC, 32'd20);
        DATA2 = 8'hF8;
        settle();
        chk("branch_not_taken_zero", {31'h0, ZERO}, 32'd0);
        chk("branch_not_taken_next", NEXT_PC, 32'd16);
        tick();
        chk("branch_not_taken_pc", PC, 32'd16);

        // Jump priority over a failing branch, from PC = 0
        RESET = 1'b1;
        model_pc = 32'h0;
        #1;
        chk("prio_reset_pc", PC, 32'h0);
        RESET = 1'b0;
        set_in(3'b001, 8'h01, 8'h01, 1'b1, 1'b1, 8'h03); settle();
        chk("prio_zero", {31'h0, ZERO}, 32'd0);
        chk("prio_next", NEXT_PC, 32'd16); tick();
        chk("prio_pc", PC, 32'd16);

        // Wrap: jump to 0xFFFF_FFFC, then sequential step wraps to 0
        set_in(3'b000, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFA); settle(); tick();
        chk("wrap_pc_top", PC, 32'hFFFF_FFFC);
        set_in(3'b000, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00); settle();
        chk("wrap_next", NEXT_PC, 32'h0); tick();
        chk("wrap_pc", PC, 32'h0);
        settle();

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
